countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 111 +++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Purpose  : 4-bit loadable down-counter with IDLE/RUN/DONE control, pause,
//            registered busy level and a one-cycle done pulse on expiry.
//            Optional auto-reload/stop behaviour is enabled by defining the
//            macro COUNTDOWN_AUTO_RELOAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer (
   input  logic       clock,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] din,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] Q,
   output logic       busy,
   output logic       done
);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   localparam logic c_AUTO_RELOAD = 1'b1;
`else
   localparam logic c_AUTO_RELOAD = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   logic [3:0] r_q;
   logic [3:0] r_rld;
   logic       r_busy;
   logic       r_done;

   // Value a start request counts from: a same-cycle load wins over Q.
   logic [3:0] w_eff;
   // Reload is only active with the feature built in and a non-zero reload.
   logic       w_reload;

   assign w_eff    = load ? din : r_q;
   assign w_reload = c_AUTO_RELOAD && (r_rld != 4'd0);

   assign Q    = r_q;
   assign busy = r_busy;
   assign done = r_done;

   // Control FSM with count, reload value and registered status outputs.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= S_IDLE;
         r_q     <= 4'd0;
         r_rld   <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            // DONE lasts a single cycle and otherwise behaves like IDLE.
            S_IDLE, S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               if (load) begin
                  r_q   <= din;
                  r_rld <= din;
               end
               if (start) begin
                  if (w_eff != 4'd0) begin
                     r_state <= S_RUN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (c_AUTO_RELOAD && start) begin
                  // Stop request: leave the count where it is, no pulse.
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (!pause) begin
                  if ((r_q == 4'd0) && w_reload) begin
                     r_q <= r_rld;
                  end else if (r_q <= 4'd1) begin
                     // Expiry; Q==0 here only occurs defensively, never wraps.
                     r_q    <= 4'd0;
                     r_done <= 1'b1;
                     if (!w_reload) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_q <= r_q - 4'd1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
